branch_redirect_ctrl: RTL and testbench

Sequences branch and jump resolution in the execute stage of the RV32I pipeline. Evaluates the branch condition, computes the target, and holds the execute stage while it redirects fetch through a valid/ready handshake. It then flushes the fetch and decode stages for a programmable number of cycles. The pipeline predicts not-taken, so not-taken branches pass with zero penalty. The block also keeps wrapping branch/taken performance counters.

---
 rtl/rv32_branch_pkg.sv | 20 ++
 rtl/branch_cmp.sv | 27 ++
 rtl/branch_redirect_ctrl.sv | 129 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_branch_pkg.sv
// Shared definitions for RV32I branch resolution:
// func3 codes, redirect FSM states, flush counter width.
package rv32_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int FCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational B-type condition evaluator.
// Ports: func3, a, b in; taken, illegal out.
module branch_cmp
    import rv32_branch_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken,
    output logic        illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) < $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = ($unsigned(a) < $unsigned(b));
            F3_BGEU: taken = ($unsigned(a) >= $unsigned(b));
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch/jump resolution: redirect
// handshake to fetch, IF/ID flush window, perf counters.
// Ports: ex_* instruction in; stall_ex, redirect_*,
// flush_if/id, misalign_err, illegal_f3, counters out.
module branch_redirect_ctrl
    import rv32_branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_func3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    output logic        stall_ex,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush_if,
    output logic        flush_id,
    output logic        misalign_err,
    output logic        illegal_f3,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    localparam logic [FCNT_W-1:0] FLOAD =
        FCNT_W'(FLUSH_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [FCNT_W-1:0] fcnt;

    logic        cmp_taken;
    logic        cmp_ill;
    logic        taken;
    logic        ill;
    logic        accept;
    logic        go;
    logic        mis;
    logic        hs;
    logic [31:0] sum_pc;
    logic [31:0] sum_rs1;
    logic [31:0] target;

    branch_cmp u_cmp (
        .func3   (ex_func3),
        .a       (ex_rs1),
        .b       (ex_rs2),
        .taken   (cmp_taken),
        .illegal (cmp_ill)
    );

    assign sum_pc  = ex_pc + ex_imm;
    assign sum_rs1 = ex_rs1 + ex_imm;

    // jalr wins over jal, jal over branch
    always_comb begin
        taken  = 1'b0;
        ill    = 1'b0;
        target = sum_pc;
        if (ex_is_jalr) begin
            taken  = 1'b1;
            target = {sum_rs1[31:1], 1'b0};
        end else if (ex_is_jal) begin
            taken  = 1'b1;
        end else if (ex_is_branch) begin
            taken  = cmp_taken;
            ill    = cmp_ill;
        end
    end

    assign accept = ex_valid
                  && (ex_is_branch || ex_is_jal
                      || ex_is_jalr)
                  && (state == IDLE);
    assign mis = accept && taken && target[1];
    assign go  = accept && taken && !target[1];
    assign hs  = (state == REDIRECT) && redirect_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (go) state_nx = REDIRECT;
            REDIRECT: if (hs) state_nx = FLUSH;
            FLUSH:    if (fcnt == '0) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fcnt         <= '0;
            redirect_pc  <= '0;
            misalign_err <= 1'b0;
            illegal_f3   <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            state        <= state_nx;
            misalign_err <= mis;
            illegal_f3   <= accept && ill;
            if (hs)
                fcnt <= FLOAD;
            else if (state == FLUSH && fcnt != '0)
                fcnt <= fcnt - 1'b1;
            if (go) begin
                redirect_pc <= target;
                taken_count <= taken_count + 1'b1;
            end
            if (accept)
                branch_count <= branch_count + 1'b1;
        end
    end

    assign redirect_valid = (state == REDIRECT);
    assign stall_ex       = (state != IDLE);
    assign flush_if       = (state == REDIRECT)
                          || (state == FLUSH);
    assign flush_id       = flush_if;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl.
// Redirect/pulse events are queued and checked by a monitor.
module tb_branch_redirect_ctrl;

    localparam logic [1:0] EV_REDIR = 2'd0;
    localparam logic [1:0] EV_MIS   = 2'd1;
    localparam logic [1:0] EV_ILL   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic        ex_is_jal = 1'b0;
    logic        ex_is_jalr = 1'b0;
    logic [2:0]  ex_func3 = '0;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_rs2 = '0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_imm = '0;
    logic        stall_ex;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready = 1'b1;
    logic        flush_if;
    logic        flush_id;
    logic        misalign_err;
    logic        illegal_f3;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    int n_tests = 0;
    int n_fail = 0;
    ev_t q[$];
    logic rv_q = 1'b0;
    logic [31:0] exp_bc = 0;
    logic [31:0] exp_tc = 0;
    int n;

    branch_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_func3       (ex_func3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .stall_ex       (stall_ex),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .misalign_err   (misalign_err),
        .illegal_f3     (illegal_f3),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k,
                        input logic [31:0] pc);
        ev_t e;
        e.kind = k;
        e.pc   = pc;
        q.push_back(e);
    endtask

    task automatic pop_chk(input logic [1:0] k,
                           input logic [31:0] pc);
        ev_t e;
        if (q.size() == 0) begin
            check("sb_unexpected_ev", {30'd0, k}, 32'hFFFF);
        end else begin
            e = q.pop_front();
            check("sb_kind", {30'd0, k}, {30'd0, e.kind});
            check("sb_pc", pc, e.pc);
        end
    endtask

    // monitor: every event the DUT presents is scored
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid && !rv_q)
                pop_chk(EV_REDIR, redirect_pc);
            if (misalign_err)
                pop_chk(EV_MIS, 32'd0);
            if (illegal_f3)
                pop_chk(EV_ILL, 32'd0);
        end
        rv_q = redirect_valid;
    end

    task automatic send(input logic br,
                        input logic jal,
                        input logic jalr,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] pc,
                        input logic [31:0] imm);
        ex_valid     = 1'b1;
        ex_is_branch = br;
        ex_is_jal    = jal;
        ex_is_jalr   = jalr;
        ex_func3     = f3;
        ex_rs1       = a;
        ex_rs2       = b;
        ex_pc        = pc;
        ex_imm       = imm;
        @(negedge clk);
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jal    = 1'b0;
        ex_is_jalr   = 1'b0;
    endtask

    task automatic run_stall(output int cnt);
        cnt = 0;
        while (stall_ex && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("stall_timeout", {31'd0, stall_ex}, 0);
    endtask

    task automatic chk_cnt(input string nm);
        check({nm, "_bc"}, branch_count, exp_bc);
        check({nm, "_tc"}, taken_count, exp_tc);
    endtask

    task automatic chk_zero(input string nm);
        check({nm, "_stall"}, {31'd0, stall_ex}, 0);
        check({nm, "_rv"}, {31'd0, redirect_valid}, 0);
        check({nm, "_rpc"}, redirect_pc, 0);
        check({nm, "_fif"}, {31'd0, flush_if}, 0);
        check({nm, "_fid"}, {31'd0, flush_id}, 0);
        check({nm, "_mis"}, {31'd0, misalign_err}, 0);
        check({nm, "_ill"}, {31'd0, illegal_f3}, 0);
        check({nm, "_bc"}, branch_count, 0);
        check({nm, "_tc"}, taken_count, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // BEQ taken, ready high: 0x100+0x20
        push(EV_REDIR, 32'h120);
        send(1, 0, 0, 3'b000, 5, 5, 32'h100, 32'h20);
        exp_bc++; exp_tc++;
        check("beq_rv", {31'd0, redirect_valid}, 1);
        check("beq_rpc", redirect_pc, 32'h120);
        run_stall(n);
        check("beq_stall_len", n, 3);
        chk_cnt("beq");

        // BLT signed: -1 < 1 taken
        push(EV_REDIR, 32'h240);
        send(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 1,
             32'h200, 32'h40);
        exp_bc++; exp_tc++;
        run_stall(n);
        check("blt_stall_len", n, 3);
        // BLTU: 0xFFFFFFFF < 1 false
        send(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 1,
             32'h300, 32'h40);
        exp_bc++;
        check("bltu_nostall", {31'd0, stall_ex}, 0);
        chk_cnt("bltu");
        // back-to-back not-taken BNE, BGE
        send(1, 0, 0, 3'b001, 7, 7, 32'h10, 32'h8);
        send(1, 0, 0, 3'b101, 1, 2, 32'h14, 32'h8);
        exp_bc += 2;
        check("b2b_nostall", {31'd0, stall_ex}, 0);
        chk_cnt("b2b");

        // JALR clears bit 0 of rs1+imm
        push(EV_REDIR, 32'h204);
        send(0, 0, 1, 3'b000, 32'h205, 0, 32'h40, 0);
        exp_bc++; exp_tc++;
        run_stall(n);
        push(EV_REDIR, 32'h204);
        send(0, 0, 1, 3'b000, 32'h203, 0, 32'h40, 1);
        exp_bc++; exp_tc++;
        run_stall(n);
        chk_cnt("jalr");
        // JALR 0x203 -> 0x202: bit 1 set, misaligned
        push(EV_MIS, 0);
        send(0, 0, 1, 3'b000, 32'h203, 0, 32'h40, 0);
        exp_bc++;
        check("jalr_mis_nostall", {31'd0, stall_ex}, 0);
        // BEQ taken to 0x102: misaligned
        push(EV_MIS, 0);
        send(1, 0, 0, 3'b000, 5, 5, 32'h100, 32'h2);
        exp_bc++;
        check("br_mis_nostall", {31'd0, stall_ex}, 0);
        chk_cnt("mis");

        // JAL with fetch not ready for 4 cycles
        redirect_ready = 1'b0;
        push(EV_REDIR, 32'h400);
        send(0, 1, 0, 3'b000, 0, 0, 32'h300, 32'h100);
        exp_bc++; exp_tc++;
        ex_valid = 1'b1;
        ex_is_branch = 1'b1;
        ex_func3 = 3'b000;
        ex_rs1 = 1; ex_rs2 = 1;
        ex_pc = 0; ex_imm = 32'h40;
        for (int i = 0; i < 4; i++) begin
            check("hold_rv", {31'd0, redirect_valid}, 1);
            check("hold_rpc", redirect_pc, 32'h400);
            check("hold_fif", {31'd0, flush_if}, 1);
            check("hold_fid", {31'd0, flush_id}, 1);
            @(negedge clk);
        end
        ex_valid = 1'b0;
        ex_is_branch = 1'b0;
        chk_cnt("hold");
        redirect_ready = 1'b1;
        run_stall(n);
        chk_cnt("hold_done");

        // func3=010 illegal, not taken
        push(EV_ILL, 0);
        send(1, 0, 0, 3'b010, 3, 3, 32'h80, 32'h10);
        exp_bc++;
        check("ill_nostall", {31'd0, stall_ex}, 0);
        chk_cnt("ill");

        // reset while in REDIRECT
        redirect_ready = 1'b0;
        push(EV_REDIR, 32'h520);
        send(1, 0, 0, 3'b000, 1, 1, 32'h500, 32'h20);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_redir");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        exp_bc = 0; exp_tc = 0;
        redirect_ready = 1'b1;

        // reset while in FLUSH
        push(EV_REDIR, 32'h620);
        send(1, 0, 0, 3'b000, 1, 1, 32'h600, 32'h20);
        @(negedge clk);
        check("in_flush_stall", {31'd0, stall_ex}, 1);
        check("in_flush_rv", {31'd0, redirect_valid}, 0);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_flush");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // normal operation after reset
        push(EV_REDIR, 32'h720);
        send(1, 0, 0, 3'b001, 1, 2, 32'h700, 32'h20);
        exp_bc = 1; exp_tc = 1;
        run_stall(n);
        check("post_rst_stall_len", n, 3);
        chk_cnt("post_rst");

        // counter wrap
        force dut.branch_count = 32'hFFFF_FFFF;
        force dut.taken_count  = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.branch_count;
        release dut.taken_count;
        exp_bc = 32'hFFFF_FFFF; exp_tc = 32'hFFFF_FFFF;
        chk_cnt("preload");
        push(EV_REDIR, 32'h820);
        send(1, 0, 0, 3'b000, 9, 9, 32'h800, 32'h20);
        exp_bc = 0; exp_tc = 0;
        chk_cnt("wrap");
        run_stall(n);

        repeat (2) @(negedge clk);
        check("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
